pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Receive-side counterpart of the PWM generator. Measures an incoming PWM signal (motor
//  feedback, RC receiver, loop-back of our own pwm_clk) and reports high time, period and
//  an 8-bit duty cycle on the same scale the generator consumes (duty = high*256/period).
//  Sits between an external pin and the Nios-facing register logic in the motor controller.
// PARAMETERS
//  CNT_W    16     width of high/period counters (cycles of clk)
//  DUTY_W   8      duty result width; also the number of divider iterations
//  TIMEOUT  65535  cycles without a rising edge before timeout; 2 <= TIMEOUT <= 2^CNT_W-1
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  pwm_in      in   1       asynchronous PWM input
//  duty_cycle  out  DUTY_W  floor(high_time*2^DUTY_W/period); 0 or all-ones on timeout
//  high_time   out  CNT_W   cycles pwm_in was high in last complete period
//  period      out  CNT_W   cycles between last two rising edges
//  valid       out  1       one-cycle strobe: outputs just updated
//  timeout     out  1       level: no rising edge for TIMEOUT cycles; cleared by next valid measurement
//  overrun     out  1       one-cycle strobe: rising edge arrived during DIVIDE, that period dropped
// BEHAVIOUR
//  - Reset: all outputs 0, state ACQUIRE, sync/edge regs 0, armed=0. Reset mid-operation aborts everything.
//  - Input: 2-FF synchronizer + previous-sample reg; rise = s & ~prev, fall = ~s & prev.
//    Edge is detected 3 clk after pwm_in changes; this offset cancels in all measurements.
//  - cnt: on rise cnt<=1, else cnt<=cnt+1 (never wraps; timeout fires first). On fall hi_lat<=cnt.
//  - ACQUIRE: armed<=1 once synchronized level is 0; rises ignored until armed. Armed rise -> MEASURE, cnt<=1.
//  - MEASURE: on rise: per_lat<=cnt, load divider (rem<=hi_lat, quotient<=0), cnt<=1, -> DIVIDE.
//  - DIVIDE: DUTY_W cycles restoring division: rem<=rem*2; if rem*2>=per_lat {rem-=per_lat; q bit=1}.
//    Divider width CNT_W+1 bits. high<period always, so quotient fits DUTY_W bits without clamp.
//    Cycle after last iteration: duty_cycle<=q, high_time<=hi_lat_at_load, period<=per_lat,
//    valid<=1, timeout<=0, -> MEASURE. Edge counting (cnt, hi_lat) continues during DIVIDE.
//  - Latency: valid asserts DUTY_W+1 cycles after the terminating rise is detected.
//  - Rise during DIVIDE: cnt<=1, overrun<=1 for one cycle, divide completes normally; period ending
//    at that rise is not reported. Periods < DUTY_W+2 cycles therefore report at most every other period.
//  - Fall and rise never coincide (single-bit edge detector). hi_lat captured for division is the
//    value at load time; a fall during DIVIDE updates hi_lat for the next period only.
//  - Timeout: in MEASURE or DIVIDE, when cnt == TIMEOUT and no rise this cycle: duty_cycle<=all-ones if
//    synchronized level is 1 else 0; high_time<=0; period<=0; timeout<=1; valid<=1; abort divide;
//    -> ACQUIRE with armed<=~level. Timeout does not re-fire while in ACQUIRE.
//  - Outputs hold their values between valid strobes.
// TESTING
//  1. Period 256, high 64 -> after 2nd rise: duty_cycle=64, high_time=64, period=256, valid 1 cycle,
//     DUTY_W+1 cycles after edge detection.
//  2. Period 1000, high 333 -> duty_cycle=85, high_time=333, period=1000; steady stream repeats each period.
//  3. TIMEOUT=1000, pwm_in held 0 -> timeout=1, duty_cycle=0, period=0, valid once; held 1 -> duty_cycle=255;
//     resume PWM -> timeout clears on the first valid measurement.
//  4. Period 6, high 3 -> overrun pulses, valid at most every 2nd period, each report duty_cycle=128.
//  5. rst asserted mid-DIVIDE -> all outputs 0 next cycle; no valid until an armed rise and one full period.
//  6. pwm_in high at reset release, period 256, high 1 -> first partial period ignored; reports duty_cycle=1.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of an asynchronous PWM input and
// derives duty = high*2^DUTY_W/period with a serial restoring divider.
module pwm_capture #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DUTY_W  = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic [CNT_W-1:0]  high_time,
    output logic [CNT_W-1:0]  period,
    output logic              valid,
    output logic              timeout,
    output logic              overrun
);

    localparam int unsigned     ITER_W    = $clog2(DUTY_W + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [ITER_W-1:0] ITER_END = ITER_W'(DUTY_W);

    typedef enum logic [1:0] {
        ACQUIRE,
        MEASURE,
        DIVIDE
    } state_t;

    state_t state, state_next;

    logic              sync1, sync2, prev;
    logic [1:0]        fill;
    logic              level, rise, fall;
    logic              armed;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  hi_lat;
    logic [CNT_W-1:0]  hi_load;
    logic [CNT_W-1:0]  per_lat;
    logic [CNT_W:0]    rem;
    logic [CNT_W:0]    rem_dbl;
    logic              rem_ge;
    logic [DUTY_W-1:0] quo;
    logic [ITER_W-1:0] iter;

    logic start_div, finish_div, fire_timeout;

    assign level = sync2;
    assign rise  = sync2 & ~prev;
    assign fall  = ~sync2 & prev;

    assign rem_dbl = rem << 1;
    assign rem_ge  = (rem_dbl >= {1'b0, per_lat});

    always_comb begin
        state_next   = state;
        start_div    = 1'b0;
        finish_div   = 1'b0;
        fire_timeout = 1'b0;
        case (state)
            ACQUIRE: begin
                if (rise && armed) state_next = MEASURE;
            end
            MEASURE: begin
                if (rise) begin
                    start_div  = 1'b1;
                    state_next = DIVIDE;
                end else if (cnt == TIMEOUT_C) begin
                    fire_timeout = 1'b1;
                    state_next   = ACQUIRE;
                end
            end
            DIVIDE: begin
                if (!rise && cnt == TIMEOUT_C) begin
                    fire_timeout = 1'b1;
                    state_next   = ACQUIRE;
                end else if (iter == ITER_END) begin
                    finish_div = 1'b1;
                    state_next = MEASURE;
                end
            end
            default: state_next = ACQUIRE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACQUIRE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            fill       <= '0;
            armed      <= 1'b0;
            cnt        <= '0;
            hi_lat     <= '0;
            hi_load    <= '0;
            per_lat    <= '0;
            rem        <= '0;
            quo        <= '0;
            iter       <= '0;
            duty_cycle <= '0;
            high_time  <= '0;
            period     <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            prev  <= sync2;
            fill  <= {fill[0], 1'b1};

            if (rise)            cnt <= CNT_W'(1);
            else if (cnt != '1)  cnt <= cnt + CNT_W'(1);
            if (fall) hi_lat <= cnt;

            valid   <= 1'b0;
            overrun <= 1'b0;

            // Arm only once the synchronizer holds real samples, so a pin that is
            // high at reset release cannot look like a fresh rising edge.
            if (state == ACQUIRE && fill[1] && !level) armed <= 1'b1;

            if (start_div) begin
                per_lat <= cnt;
                hi_load <= hi_lat;
                rem     <= {1'b0, hi_lat};
                quo     <= '0;
                iter    <= '0;
            end else if (state == DIVIDE && iter != ITER_END) begin
                rem  <= rem_ge ? (rem_dbl - {1'b0, per_lat}) : rem_dbl;
                quo  <= {quo[DUTY_W-2:0], rem_ge};
                iter <= iter + ITER_W'(1);
            end

            if (state == DIVIDE && rise) overrun <= 1'b1;

            if (finish_div) begin
                duty_cycle <= quo;
                high_time  <= hi_load;
                period     <= per_lat;
                valid      <= 1'b1;
                timeout    <= 1'b0;
            end

            if (fire_timeout) begin
                duty_cycle <= level ? '1 : '0;
                high_time  <= '0;
                period     <= '0;
                valid      <= 1'b1;
                timeout    <= 1'b1;
                armed      <= ~level;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: scoreboard of expected reports checked on every valid strobe.
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DUTY_W  = 8;
    localparam int unsigned TIMEOUT = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pwm_in = 1'b0;
    logic [DUTY_W-1:0] duty_cycle;
    logic [CNT_W-1:0]  high_time;
    logic [CNT_W-1:0]  period;
    logic              valid;
    logic              timeout;
    logic              overrun;

    pwm_capture #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .duty_cycle(duty_cycle),
        .high_time (high_time),
        .period    (period),
        .valid     (valid),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int high;
        int per;
        int to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   ovr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int duty_of(input int h, input int p);
        return (h << DUTY_W) / p;
    endfunction

    task automatic push(input int d, input int h, input int p, input int t);
        exp_t e;
        e.duty = d; e.high = h; e.per = p; e.to = t;
        sb.push_back(e);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_duty"},    32'(duty_cycle), 0);
        check({tag, "_high"},    32'(high_time),  0);
        check({tag, "_period"},  32'(period),     0);
        check({tag, "_valid"},   32'(valid),      0);
        check({tag, "_timeout"}, 32'(timeout),    0);
        check({tag, "_overrun"}, 32'(overrun),    0);
    endtask

    // n complete periods, each terminated by the following rise, which reports it
    task automatic pwm_run(input int high, input int per, input int n);
        for (int i = 0; i <= n; i++) begin
            if (i > 0) push(duty_of(high, per), high, per, 0);
            pwm_in = 1'b1;
            cyc(high);
            pwm_in = 1'b0;
            cyc(i == n ? 20 : per - high);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                check("valid_unexpected", 32'(valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("duty_cycle", 32'(duty_cycle), e.duty);
                check("high_time",  32'(high_time),  e.high);
                check("period",     32'(period),     e.per);
                check("timeout",    32'(timeout),    e.to);
            end
        end
        if (overrun) ovr_cnt++;
    end

    initial begin
        int lat;

        // reset state
        pwm_in = 1'b0;
        rst    = 1'b1;
        cyc(3);
        check_zero_outputs("reset");
        rst = 1'b0;
        cyc(5);

        // period 256 / high 64, with latency and strobe width
        pwm_in = 1'b1; cyc(64); pwm_in = 1'b0; cyc(192);
        push(64, 64, 256, 0);
        pwm_in = 1'b1;
        lat = 0;
        while (lat < 20) begin
            cyc(1);
            lat++;
            if (valid) break;
        end
        // 3 cycles of synchronizer/edge detect, then DUTY_W+1 to the strobe
        check("valid_latency", 32'(lat), DUTY_W + 4);
        cyc(1);
        lat++;
        check("valid_one_cycle", 32'(valid), 0);
        cyc(64 - lat); pwm_in = 1'b0; cyc(192);
        push(64, 64, 256, 0);
        pwm_in = 1'b1; cyc(64); pwm_in = 1'b0; cyc(20);
        check("test1_drained", 32'(sb.size()), 0);

        // period 1000 / high 333, steady stream; period equals TIMEOUT
        do_reset();
        cyc(5);
        pwm_run(333, 1000, 3);
        check("test2_drained", 32'(sb.size()), 0);

        // timeout with input held low, then held high, then recovery
        do_reset();
        cyc(5);
        push(0, 0, 0, 1);
        pwm_in = 1'b1; cyc(5); pwm_in = 1'b0;
        cyc(TIMEOUT + 20);
        check("timeout_low_level", 32'(timeout), 1);
        cyc(TIMEOUT + 100);
        check("timeout_no_refire", 32'(sb.size()), 0);
        check("timeout_held", 32'(timeout), 1);
        push(255, 0, 0, 1);
        pwm_in = 1'b1;
        cyc(TIMEOUT + 20);
        check("timeout_high_level", 32'(timeout), 1);
        check("timeout_high_drained", 32'(sb.size()), 0);
        pwm_in = 1'b0;
        cyc(10);
        pwm_run(100, 400, 1);
        check("timeout_cleared", 32'(timeout), 0);

        // period 6 / high 3: every other rise lands in DIVIDE and is dropped
        do_reset();
        cyc(5);
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 1) push(duty_of(3, 6), 3, 6, 0);
            pwm_in = 1'b1; cyc(3);
            pwm_in = 1'b0; cyc(3);
        end
        cyc(20);
        check("overrun_count", 32'(ovr_cnt), 4);
        check("test4_drained", 32'(sb.size()), 0);

        // reset mid-DIVIDE
        do_reset();
        cyc(5);
        pwm_run(64, 256, 1);
        cyc(256 - 64 - 20);
        pwm_in = 1'b1;
        cyc(7);
        rst = 1'b1;
        cyc(1);
        check_zero_outputs("mid_divide_reset");
        rst = 1'b0;
        cyc(56);
        pwm_in = 1'b0; cyc(192);
        pwm_in = 1'b1; cyc(64); pwm_in = 1'b0; cyc(192);
        push(duty_of(64, 256), 64, 256, 0);
        pwm_in = 1'b1; cyc(64); pwm_in = 1'b0; cyc(20);
        check("test5_drained", 32'(sb.size()), 0);

        // pwm_in high across reset release, high 1 of 256
        pwm_in = 1'b1;
        do_reset();
        cyc(30);
        pwm_in = 1'b0;
        cyc(100);
        pwm_run(1, 256, 2);
        check("test6_drained", 32'(sb.size()), 0);
        check("overrun_total", 32'(ovr_cnt), 4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
